// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: sequential fetch requests with multiple in flight, an in-order
// {pc,instr} buffer towards decode, and redirects that flush it and discard stale responses.
module if_fetch_unit #(
   parameter int              XLEN             = 32,
   parameter logic [XLEN-1:0] CPU_RESET_VECTOR = '0,
   parameter int              FIFO_DEPTH       = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req_valid,
   input  logic            i_imem_req_ready,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_pc,
   output logic [XLEN-1:0] if_pc_p4,
   output logic [XLEN-1:0] if_instr
);

   localparam int              CW      = $clog2(FIFO_DEPTH + 1);
   localparam int              PW      = $clog2(FIFO_DEPTH);
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
   localparam logic [CW:0]     CREDITS = (CW + 1)'(FIFO_DEPTH);

   logic [XLEN-1:0] fetch_pc_r;
   logic [XLEN-1:0] rsp_pc_r;
   logic [CW-1:0]   outst_r;
   logic [CW-1:0]   drop_r;
   logic [CW-1:0]   count_r;
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic [XLEN-1:0] pc_mem_r    [FIFO_DEPTH];
   logic [XLEN-1:0] instr_mem_r [FIFO_DEPTH];

   logic [CW:0]     inflight_s;
   logic            credit_ok_s;
   logic            req_fire_s;
   logic            push_s;
   logic            pop_s;
   logic [XLEN-1:0] redir_pc_s;
   logic [CW-1:0]   outst_nxt_s;
   logic [CW-1:0]   drop_nxt_s;
   logic [CW-1:0]   count_nxt_s;

   // Issue/response/handshake decode and next-state for the counters
   always_comb begin
      inflight_s       = {1'b0, outst_r} + {1'b0, count_r};
      credit_ok_s      = (inflight_s < CREDITS);
      o_imem_req_valid = !rst && !i_redirect_valid && credit_ok_s;
      o_imem_req_addr  = fetch_pc_r;
      req_fire_s       = o_imem_req_valid && i_imem_req_ready;
      // A response arriving with a redirect belongs to the abandoned stream
      push_s           = i_imem_rsp_valid && (drop_r == {CW{1'b0}}) && !i_redirect_valid;
      if_valid         = !rst && (count_r != {CW{1'b0}}) && !i_redirect_valid;
      pop_s            = if_valid && if_ready;
      if_pc            = pc_mem_r[rd_ptr_r];
      if_instr         = instr_mem_r[rd_ptr_r];
      if_pc_p4         = pc_mem_r[rd_ptr_r] + PC_STEP;
      redir_pc_s       = {i_redirect_pc[XLEN-1:2], 2'b00};
      outst_nxt_s      = outst_r + CW'(req_fire_s) - CW'(i_imem_rsp_valid);

      if (i_redirect_valid) begin
         drop_nxt_s  = outst_r - CW'(i_imem_rsp_valid);
         count_nxt_s = {CW{1'b0}};
      end else if (i_imem_rsp_valid && (drop_r != {CW{1'b0}})) begin
         drop_nxt_s  = drop_r - CW'(1'b1);
         count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      end else begin
         drop_nxt_s  = drop_r;
         count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Control state: PCs, credit counters and buffer pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_r <= CPU_RESET_VECTOR;
         rsp_pc_r   <= CPU_RESET_VECTOR;
         outst_r    <= {CW{1'b0}};
         drop_r     <= {CW{1'b0}};
         count_r    <= {CW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
      end else begin
         outst_r <= outst_nxt_s;
         drop_r  <= drop_nxt_s;
         count_r <= count_nxt_s;
         if (i_redirect_valid) begin
            fetch_pc_r <= redir_pc_s;
            rsp_pc_r   <= redir_pc_s;
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
         end else begin
            if (req_fire_s) begin
               fetch_pc_r <= fetch_pc_r + PC_STEP;
            end
            if (push_s) begin
               rsp_pc_r <= rsp_pc_r + PC_STEP;
               wr_ptr_r <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
         end
      end
   end

   // Buffer storage; contents are only observed behind a valid count, so no reset
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         pc_mem_r[wr_ptr_r]    <= rsp_pc_r;
         instr_mem_r[wr_ptr_r] <= i_imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table emulating a 1-cycle memory,
// followed by hand sequences for drops, redirect-with-response, PC wrap and mid-run reset.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir;
   logic [31:0] redir_pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_pc_p4;
   logic [31:0] if_instr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   if_fetch_unit #(.XLEN(32), .CPU_RESET_VECTOR(32'h0000_0100), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_pc_p4(if_pc_p4), .if_instr(if_instr)
   );

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        rv;
      logic [31:0] rdata;
      logic        ifr;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_if;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic rd, input logic [31:0] rp, input logic rdy,
                      input logic rv, input logic [31:0] rdat, input logic ifr,
                      input logic eq, input logic [31:0] ea, input logic ei,
                      input logic [31:0] ep, input logic [31:0] ein);
      vec_t v;
      v.rst = r; v.redir = rd; v.rpc = rp; v.rdy = rdy; v.rv = rv; v.rdata = rdat; v.ifr = ifr;
      v.e_req = eq; v.e_addr = ea; v.e_if = ei; v.e_pc = ep; v.e_instr = ein;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge and settle before checking
   task automatic drive(input logic r, input logic rd, input logic [31:0] rp, input logic rdy,
                        input logic rv, input logic [31:0] rdat, input logic ifr);
      @(negedge clk);
      rst = r; redir = rd; redir_pc = rp; req_ready = rdy;
      rsp_valid = rv; rsp_data = rdat; if_ready = ifr;
      #1;
   endtask

   task automatic expect_out(input string nm, input logic eq, input logic [31:0] ea,
                             input logic ei, input logic [31:0] ep, input logic [31:0] ein);
      chk({nm, " req_valid"}, {31'd0, req_valid}, {31'd0, eq});
      if (eq) chk({nm, " req_addr"}, req_addr, ea);
      chk({nm, " if_valid"}, {31'd0, if_valid}, {31'd0, ei});
      if (ei) begin
         chk({nm, " if_pc"}, if_pc, ep);
         chk({nm, " if_instr"}, if_instr, ein);
         chk({nm, " if_pc_p4"}, if_pc_p4, ep + 32'd4);
      end
   endtask

   initial begin
      rst = 1'b1; redir = 1'b0; redir_pc = 32'd0; req_ready = 1'b0;
      rsp_valid = 1'b0; rsp_data = 32'd0; if_ready = 1'b0;

      // rst redir rpc rdy rv rdata ifr | req addr if pc instr
      add(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0,          1'b0,32'h0,  1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1,          1'b1,32'h100,1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0100,1'b1,  1'b1,32'h104,1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0104,1'b1,  1'b1,32'h108,1'b1,32'h100,32'h1000_0100);
      add(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0108,1'b0,  1'b1,32'h10C,1'b1,32'h104,32'h1000_0104);
      add(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_010C,1'b0,  1'b1,32'h110,1'b1,32'h104,32'h1000_0104);
      add(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0110,1'b0,  1'b0,32'h0,  1'b1,32'h104,32'h1000_0104);
      add(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0,          1'b0,32'h0,  1'b1,32'h104,32'h1000_0104);
      add(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1,          1'b0,32'h0,  1'b1,32'h104,32'h1000_0104);
      add(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1,          1'b1,32'h114,1'b1,32'h108,32'h1000_0108);
      add(1'b0,1'b0,32'h0,1'b0,1'b1,32'h1000_0114,1'b1,  1'b1,32'h118,1'b1,32'h10C,32'h1000_010C);
      add(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,          1'b1,32'h118,1'b1,32'h110,32'h1000_0110);
      add(1'b0,1'b1,32'h2003,1'b1,1'b0,32'h0,1'b1,       1'b0,32'h0,  1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1,          1'b1,32'h2000,1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b0,1'b1,32'h1000_2000,1'b1,  1'b1,32'h2004,1'b0,32'h0,32'h0);
      add(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,          1'b1,32'h2004,1'b1,32'h2000,32'h1000_2000);
      add(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1,          1'b1,32'h2004,1'b0,32'h0,32'h0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].ifr);
         expect_out($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_if, tbl[i].e_pc, tbl[i].e_instr);
      end

      // Two requests in flight, redirect: both late responses must be dropped
      drive(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0);
      expect_out("drop issue0", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0);
      expect_out("drop issue1", 1'b1, 32'h104, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b1,32'h2003,1'b0,1'b0,32'h0,1'b1);
      expect_out("drop redir", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b1,32'hDEAD_0100,1'b1);
      expect_out("drop stale0", 1'b1, 32'h2000, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b1,32'hDEAD_0104,1'b1);
      expect_out("drop stale1", 1'b1, 32'h2004, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b1,32'h1000_2000,1'b1);
      expect_out("drop fresh", 1'b1, 32'h2004, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1);
      expect_out("drop out", 1'b1, 32'h2004, 1'b1, 32'h2000, 32'h1000_2000);

      // Redirect coinciding with a response while credits are exhausted
      drive(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0100,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0104,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b1,32'h1000_0108,1'b0);
      expect_out("full last", 1'b1, 32'h10C, 1'b1, 32'h100, 32'h1000_0100);
      drive(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      expect_out("full credits", 1'b0, 32'h0, 1'b1, 32'h100, 32'h1000_0100);
      drive(1'b0,1'b1,32'h300,1'b1,1'b1,32'hBAD0_010C,1'b1);
      expect_out("full redir", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b1);
      expect_out("full flushed", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b1,32'h1000_0300,1'b0);
      expect_out("full rsp", 1'b1, 32'h304, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      expect_out("full out", 1'b1, 32'h304, 1'b1, 32'h300, 32'h1000_0300);

      // Fetch PC wraps past the top of the address space; low redirect bits ignored
      drive(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      drive(1'b0,1'b1,32'hFFFF_FFFE,1'b0,1'b0,32'h0,1'b0);
      drive(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,1'b0);
      expect_out("wrap top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b1,32'hCAFE_0000,1'b0);
      expect_out("wrap zero", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b0);
      chk("wrap if_valid", {31'd0, if_valid}, 32'd1);
      chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap if_pc_p4", if_pc_p4, 32'h0);
      chk("wrap if_instr", if_instr, 32'hCAFE_0000);

      // Reset in the middle of operation clears buffer and fetch PC
      drive(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1);
      expect_out("mid rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      drive(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,1'b1);
      expect_out("post rst", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
